// File: rtl/maszyna_w_sequencer.sv
// Microprogrammed controller for the Machine W core: instruction fetch, KOD decode
// and microprogram execution, with run / instruction-step / tact-step modes.
module maszyna_w_sequencer #(
   parameter int WORD_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 8,
   parameter int KOD_WIDTH     = WORD_WIDTH - ADDRESS_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic [1:0]           mode,
   input  logic                 step,
   input  logic                 override_busy,
   input  logic [KOD_WIDTH-1:0] kod,
   input  logic                 zf,
   input  logic                 zak,
   input  logic [31:0]          signal_errors,
   output logic [31:0]          signals,
   output logic                 running,
   output logic                 halted,
   output logic                 fault,
   output logic [1:0]           fault_code,
   output logic [2:0]           tact,
   output logic                 instr_done,
   output logic [15:0]          instr_count
);

   // Bit positions inside the core control vector.
   localparam int WYAK  = 0;
   localparam int WWEAK = 1;
   localparam int ODE   = 2;
   localparam int DOD   = 3;
   localparam int WYAD  = 4;
   localparam int WEI   = 5;
   localparam int IL    = 6;
   localparam int WYL   = 7;
   localparam int WEL   = 8;
   localparam int WEA   = 9;
   localparam int WYS   = 10;
   localparam int WES   = 11;
   localparam int CZYT  = 12;
   localparam int PISZ  = 13;
   localparam int WEJA  = 14;
   localparam int PRZEP = 15;

   typedef enum logic [3:0] {
      S_IDLE, S_F1, S_F2, S_F3, S_X1, S_X2, S_X3, S_HALT, S_FAULT
   } state_t;

   typedef enum logic [2:0] {
      OP_STP, OP_DOD, OP_ODE, OP_POB, OP_LAD, OP_SOB, OP_SOM, OP_SOZ
   } opcode_t;

   typedef enum logic [1:0] {
      FC_NONE     = 2'd0,
      FC_ILLEGAL  = 2'd1,
      FC_CONFLICT = 2'd2
   } fault_code_t;

   state_t      state, state_d;
   fault_code_t fault_q, fault_d;
   logic        stop_pending, stop_pending_d;
   logic        done_d;

   logic [15:0] micro;
   logic        last_step;
   logic        illegal;
   logic        en;
   logic        kod_high;
   opcode_t     op;

   assign op       = opcode_t'(kod[2:0]);
   assign kod_high = |kod[KOD_WIDTH-1:3];

   assign running = (state inside {S_F1, S_F2, S_F3, S_X1, S_X2, S_X3});
   assign halted  = (state == S_HALT);
   assign fault   = (state == S_FAULT);
   assign fault_code = fault_q;

   // Tact-step mode advances only on cycles where step is high.
   assign en = running & ~override_busy & ((mode != 2'd2) | step);

   // Microinstruction decode from the registered state and the core's KOD/flags.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      micro     = '0;
      last_step = 1'b0;
      illegal   = 1'b0;
      case (state)
         S_F1: begin
            micro[WYL] = 1'b1;
            micro[WEA] = 1'b1;
            micro[IL]  = 1'b1;
         end
         S_F2: micro[CZYT] = 1'b1;
         S_F3: begin
            micro[WYS] = 1'b1;
            micro[WEI] = 1'b1;
         end
         S_X1: begin
            if (kod_high) begin
               illegal = 1'b1;
            end else begin
               case (op)
                  OP_STP: last_step = 1'b1;
                  OP_DOD, OP_ODE, OP_POB: begin
                     micro[WYAD] = 1'b1;
                     micro[WEA]  = 1'b1;
                  end
                  OP_LAD: begin
                     micro[WYAD] = 1'b1;
                     micro[WEA]  = 1'b1;
                     micro[WYAK] = 1'b1;
                     micro[WES]  = 1'b1;
                  end
                  OP_SOB: begin
                     micro[WYAD] = 1'b1;
                     micro[WEL]  = 1'b1;
                     last_step   = 1'b1;
                  end
                  OP_SOM: begin
                     micro[WYAD] = zf;
                     micro[WEL]  = zf;
                     last_step   = 1'b1;
                  end
                  OP_SOZ: begin
                     micro[WYAD] = zak;
                     micro[WEL]  = zak;
                     last_step   = 1'b1;
                  end
               endcase
            end
         end
         S_X2: begin
            if (op == OP_LAD) begin
               micro[PISZ] = 1'b1;
               last_step   = 1'b1;
            end else begin
               micro[CZYT] = 1'b1;
            end
         end
         S_X3: begin
            micro[WYS]   = 1'b1;
            micro[WEJA]  = 1'b1;
            micro[WWEAK] = 1'b1;
            case (op)
               OP_DOD:  micro[DOD]   = 1'b1;
               OP_ODE:  micro[ODE]   = 1'b1;
               default: micro[PRZEP] = 1'b1;
            endcase
            last_step = 1'b1;
         end
         default: ;
      endcase
   end

   assign signals = en ? {16'h0000, micro} : 32'h0000_0000;

   always_comb begin
      case (state)
         S_F1:    tact = 3'd0;
         S_F2:    tact = 3'd1;
         S_F3:    tact = 3'd2;
         S_X1:    tact = 3'd3;
         S_X2:    tact = 3'd4;
         S_X3:    tact = 3'd5;
         default: tact = 3'd0;
      endcase
   end

   always_comb begin
      state_d        = state;
      fault_d        = fault_q;
      stop_pending_d = stop_pending | stop;
      done_d         = 1'b0;

      if (!running) begin
         if (start && !override_busy) begin
            state_d        = S_F1;
            fault_d        = FC_NONE;
            stop_pending_d = stop;
         end
      end else if (en) begin
         if (|signal_errors) begin
            state_d = S_FAULT;
            fault_d = FC_CONFLICT;
         end else if (illegal) begin
            state_d = S_FAULT;
            fault_d = FC_ILLEGAL;
         end else if (last_step) begin
            done_d = 1'b1;
            if (state == S_X1 && op == OP_STP) begin
               state_d = S_HALT;
            end else if (stop_pending || stop || mode == 2'd1) begin
               state_d        = S_IDLE;
               stop_pending_d = 1'b0;
            end else begin
               state_d = S_F1;
            end
         end else begin
            case (state)
               S_F1:    state_d = S_F2;
               S_F2:    state_d = S_F3;
               S_F3:    state_d = S_X1;
               S_X1:    state_d = S_X2;
               S_X2:    state_d = S_X3;
               default: state_d = S_FAULT;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         fault_q      <= FC_NONE;
         stop_pending <= 1'b0;
         instr_done   <= 1'b0;
         instr_count  <= 16'h0000;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state        <= state_d;
         fault_q      <= fault_d;
         stop_pending <= stop_pending_d;
         instr_done   <= done_d;
         if (done_d) begin
            instr_count <= instr_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_maszyna_w_sequencer.sv
// Self-checking bench for maszyna_w_sequencer: drives a small Machine W core model
// from the control vector and compares against tables and an instruction-level model.
module tb_maszyna_w_sequencer;

   localparam int KW = 24;
   localparam int WYAK = 0, WWEAK = 1, ODE = 2, DOD = 3, WYAD = 4, WEI = 5, IL = 6, WYL = 7;
   localparam int WEL = 8, WEA = 9, WYS = 10, WES = 11, CZYT = 12, PISZ = 13, PRZEP = 15;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0, step = 1'b0, override_busy = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [31:0]   sig_err = 32'h0;
   logic [KW-1:0] kod;
   logic          zf, zak;
   logic [31:0]   signals;
   logic          running, halted, fault, instr_done;
   logic [1:0]    fault_code;
   logic [2:0]    tact;
   logic [15:0]   instr_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   maszyna_w_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode), .step(step),
      .override_busy(override_busy), .kod(kod), .zf(zf), .zak(zak),
      .signal_errors(sig_err), .signals(signals), .running(running), .halted(halted),
      .fault(fault), .fault_code(fault_code), .tact(tact), .instr_done(instr_done),
      .instr_count(instr_count)
   );

   // Core datapath model reacting to the control vector.
   logic [31:0] mem [256];
   logic [7:0]  reg_a, reg_l;
   logic [31:0] reg_i, reg_s, reg_ak;
   logic        ld_mem_en = 1'b0, ld_regs_en = 1'b0;
   logic [7:0]  ld_addr = 8'h0, ld_l = 8'h0;
   logic [31:0] ld_data = 32'h0, ld_ak = 32'h0;
   logic [7:0]  bus_a;
   logic [31:0] bus_s, jal;

   always_comb begin
      bus_a = (signals[WYL] ? reg_l : 8'h0) | (signals[WYAD] ? reg_i[31:24] : 8'h0);
      bus_s = (signals[WYS] ? reg_s : 32'h0) | (signals[WYAK] ? reg_ak : 32'h0);
      if (signals[PRZEP])    jal = bus_s;
      else if (signals[DOD]) jal = reg_ak + bus_s;
      else if (signals[ODE]) jal = reg_ak - bus_s;
      else                   jal = reg_ak;
   end

   assign kod = reg_i[23:0];
   assign zf  = reg_ak[31];
   assign zak = (reg_ak == 32'h0);

   always @(posedge clk) begin
      if (ld_mem_en) mem[ld_addr] <= ld_data;
      if (ld_regs_en) begin
         reg_ak <= ld_ak;
         reg_l  <= ld_l;
      end
      if (signals[WEA])   reg_a  <= bus_a;
      if (signals[IL])    reg_l  <= reg_l + 8'd1;
      if (signals[WEL])   reg_l  <= bus_a;
      if (signals[CZYT])  reg_s  <= mem[reg_a];
      if (signals[WES])   reg_s  <= bus_s;
      if (signals[WEI])   reg_i  <= bus_s;
      if (signals[WWEAK]) reg_ak <= jal;
      if (signals[PISZ])  mem[reg_a] <= reg_s;
   end

   logic [31:0] model_mem [256];

   typedef struct {
      string            name;
      logic [31:0]      word;
      logic [31:0]      ak;
      int               len;
      logic [5:0][15:0] sig;
      logic [7:0]       l_after;
      logic             halt;
   } vec_t;

   vec_t vecs [10];

   function automatic vec_t mk(string n, logic [31:0] w, logic [31:0] ak, int len,
                               logic [15:0] x1, logic [15:0] x2, logic [15:0] x3,
                               logic [7:0] l, logic h);
      vec_t r;
      r.name = n; r.word = w; r.ak = ak; r.len = len;
      r.sig = {x3, x2, x1, 16'h0420, 16'h1000, 16'h02C0};
      r.l_after = l; r.halt = h;
      return r;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_mem(input logic [7:0] a, input logic [31:0] d);
      ld_mem_en = 1'b1; ld_addr = a; ld_data = d;
      model_mem[a] = d;
      tick();
      ld_mem_en = 1'b0;
   endtask

   task automatic set_regs(input logic [31:0] ak, input logic [7:0] l);
      ld_regs_en = 1'b1; ld_ak = ak; ld_l = l;
      tick();
      ld_regs_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_until_stopped(input int budget, output int cyc);
      cyc = 0;
      while (running && cyc < budget) begin
         cyc++;
         tick();
      end
      check("run bound", {31'b0, running}, 32'd0);
   endtask

   task automatic wait_tact(input logic [2:0] t, input int budget);
      int n = 0;
      while (!(running && tact == t) && n < budget) begin
         n++;
         tick();
      end
      check("wait tact", {31'b0, (running && tact == t)}, 32'd1);
   endtask

   // Instruction-level model: walks the program in model_mem until STP.
   task automatic isa(input logic [31:0] ak0, output logic [31:0] ak, output logic [7:0] l,
                      output int cyc, output int cnt);
      logic [7:0]  pc, a;
      logic [31:0] w;
      int          op;
      bit          done;
      pc = 8'd0; ak = ak0; cyc = 0; cnt = 0; done = 1'b0;
      while (!done && cnt < 300) begin
         w  = model_mem[pc];
         a  = w[31:24];
         op = int'(w[23:0]);
         pc = pc + 8'd1;
         cnt++;
         cyc += (op == 1 || op == 2 || op == 3) ? 6 : (op == 4) ? 5 : 4;
         case (op)
            0: done = 1'b1;
            1: ak = ak + model_mem[a];
            2: ak = ak - model_mem[a];
            3: ak = model_mem[a];
            4: model_mem[a] = ak;
            5: pc = a;
            6: if (ak[31]) pc = a;
            7: if (ak == 32'h0) pc = a;
            default: done = 1'b1;
         endcase
      end
      l = pc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc, mcyc, mcnt, n, mism;
      logic [15:0] cnt0;
      logic [31:0] mak, ak0, w;
      logic [7:0]  ml, a;
      logic [15:0] fetch [3];
      fetch[0] = 16'h02C0; fetch[1] = 16'h1000; fetch[2] = 16'h0420;

      vecs[0] = mk("DOD",     32'h09000001, 32'h0,        6, 16'h0210, 16'h1000, 16'h440A, 8'd1, 1'b0);
      vecs[1] = mk("ODE",     32'h09000002, 32'h0,        6, 16'h0210, 16'h1000, 16'h4406, 8'd1, 1'b0);
      vecs[2] = mk("POB",     32'h09000003, 32'h0,        6, 16'h0210, 16'h1000, 16'hC402, 8'd1, 1'b0);
      vecs[3] = mk("LAD",     32'h09000004, 32'h0,        5, 16'h0A11, 16'h2000, 16'h0,    8'd1, 1'b0);
      vecs[4] = mk("SOB",     32'h09000005, 32'h0,        4, 16'h0110, 16'h0,    16'h0,    8'd9, 1'b0);
      vecs[5] = mk("SOM neg", 32'h09000006, 32'h80000000, 4, 16'h0110, 16'h0,    16'h0,    8'd9, 1'b0);
      vecs[6] = mk("SOM pos", 32'h09000006, 32'h00000001, 4, 16'h0,    16'h0,    16'h0,    8'd1, 1'b0);
      vecs[7] = mk("SOZ zero",32'h09000007, 32'h0,        4, 16'h0110, 16'h0,    16'h0,    8'd9, 1'b0);
      vecs[8] = mk("SOZ nz",  32'h09000007, 32'h00000005, 4, 16'h0,    16'h0,    16'h0,    8'd1, 1'b0);
      vecs[9] = mk("STP",     32'h09000000, 32'h0,        4, 16'h0,    16'h0,    16'h0,    8'd1, 1'b1);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst signals", signals, 32'h0);
      check("rst running", {31'b0, running}, 32'd0);
      check("rst halted", {31'b0, halted}, 32'd0);
      check("rst fault", {31'b0, fault}, 32'd0);
      check("rst fault_code", {30'b0, fault_code}, 32'd0);
      check("rst tact", {29'b0, tact}, 32'd0);
      check("rst instr_done", {31'b0, instr_done}, 32'd0);
      check("rst instr_count", {16'b0, instr_count}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Four-instruction program in run mode
      load_mem(0, 32'h05000003); load_mem(1, 32'h06000001); load_mem(2, 32'h07000004);
      load_mem(3, 32'h00000000); load_mem(5, 32'd3); load_mem(6, 32'd4); load_mem(7, 32'd0);
      set_regs(32'h0, 8'h0);
      mode = 2'd0;
      pulse_start();
      run_until_stopped(100, cyc);
      check("prog cycles", cyc, 32'd21);
      check("prog halted", {31'b0, halted}, 32'd1);
      check("prog ak", reg_ak, 32'd7);
      check("prog mem7", mem[7], 32'd7);
      check("prog count", {16'b0, instr_count}, 32'd4);
      check("prog L", {24'b0, reg_l}, 32'd4);
      check("prog done pulse", {31'b0, instr_done}, 32'd1);
      tick();
      check("prog done low", {31'b0, instr_done}, 32'd0);

      // Per-opcode microprograms in instruction-step mode
      for (int i = 0; i < 10; i++) begin
         load_mem(0, vecs[i].word);
         set_regs(vecs[i].ak, 8'h0);
         mode = 2'd1;
         pulse_start();
         for (int t = 0; t < vecs[i].len; t++) begin
            check($sformatf("%s t%0d signals", vecs[i].name, t), signals, {16'h0, vecs[i].sig[t]});
            check($sformatf("%s t%0d tact", vecs[i].name, t), {29'b0, tact}, t);
            tick();
         end
         check($sformatf("%s running", vecs[i].name), {31'b0, running}, 32'd0);
         check($sformatf("%s halted", vecs[i].name), {31'b0, halted}, {31'b0, vecs[i].halt});
         check($sformatf("%s done", vecs[i].name), {31'b0, instr_done}, 32'd1);
         check($sformatf("%s L", vecs[i].name), {24'b0, reg_l}, {24'b0, vecs[i].l_after});
      end

      // Tact-step mode
      load_mem(0, 32'h06000001); load_mem(1, 32'h0); load_mem(6, 32'd4);
      set_regs(32'd10, 8'h0);
      mode = 2'd2;
      pulse_start();
      check("step idle sig", signals, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         #1;
         check($sformatf("step %0d sig", i), signals, {16'h0, fetch[i]});
         check($sformatf("step %0d tact", i), {29'b0, tact}, i);
         tick();
         step = 1'b0;
         #1;
         check($sformatf("step %0d gap sig", i), signals, 32'h0);
         check($sformatf("step %0d gap tact", i), {29'b0, tact}, i + 1);
      end
      step = 1'b1; stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      tick();
      step = 1'b0;
      check("step end running", {31'b0, running}, 32'd0);
      check("step end done", {31'b0, instr_done}, 32'd1);
      check("step end ak", reg_ak, 32'd14);

      // Override freeze during X2 of DOD
      set_regs(32'd10, 8'h0);
      mode = 2'd0;
      pulse_start();
      wait_tact(3'd4, 20);
      override_busy = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("ovr %0d sig", i), signals, 32'h0);
         check($sformatf("ovr %0d tact", i), {29'b0, tact}, 32'd4);
         tick();
      end
      override_busy = 1'b0;
      #1;
      check("ovr resume sig", signals, 32'h0000_1000);
      run_until_stopped(20, cyc);
      check("ovr halted", {31'b0, halted}, 32'd1);
      check("ovr ak", reg_ak, 32'd14);

      // Illegal opcode
      load_mem(0, 32'h00000009); load_mem(1, 32'h0);
      set_regs(32'h0, 8'h0);
      cnt0 = instr_count;
      pulse_start();
      run_until_stopped(20, cyc);
      check("ill cycles", cyc, 32'd4);
      check("ill fault", {31'b0, fault}, 32'd1);
      check("ill code", {30'b0, fault_code}, 32'd1);
      check("ill count", {16'b0, instr_count}, {16'b0, cnt0});
      pulse_start();
      check("ill restart running", {31'b0, running}, 32'd1);
      check("ill restart tact", {29'b0, tact}, 32'd0);
      check("ill restart fault", {31'b0, fault}, 32'd0);
      check("ill restart code", {30'b0, fault_code}, 32'd0);
      run_until_stopped(20, cyc);
      check("ill restart halted", {31'b0, halted}, 32'd1);

      // Signal conflict is sticky until start
      load_mem(0, 32'h00000005);
      set_regs(32'h0, 8'h0);
      pulse_start();
      tick();
      tick();
      sig_err = 32'h0000_0100;
      tick();
      sig_err = 32'h0;
      check("conf fault", {31'b0, fault}, 32'd1);
      check("conf code", {30'b0, fault_code}, 32'd2);
      check("conf running", {31'b0, running}, 32'd0);
      tick();
      tick();
      check("conf sticky", {30'b0, fault_code}, 32'd2);
      set_regs(32'h0, 8'h0);
      mode = 2'd1;
      pulse_start();
      check("conf cleared", {30'b0, fault_code}, 32'd0);
      run_until_stopped(20, cyc);
      check("conf idle halted", {31'b0, halted}, 32'd0);

      // start and stop together from IDLE
      mode = 2'd0;
      cnt0 = instr_count;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      run_until_stopped(20, cyc);
      check("ss cycles", cyc, 32'd4);
      check("ss halted", {31'b0, halted}, 32'd0);
      check("ss count", {16'b0, instr_count}, {16'b0, cnt0 + 16'd1});

      // Random programs against the instruction-level model
      for (int p = 0; p < 6; p++) begin
         n = $urandom_range(4, 10);
         for (int pc = 0; pc < n; pc++) begin
            int op = $urandom_range(1, 7);
            if (op <= 4) a = 8'($urandom_range(200, 215));
            else         a = 8'($urandom_range(pc + 1, (pc + 3 > n) ? n : pc + 3));
            w = {a, 24'(op)};
            load_mem(8'(pc), w);
         end
         load_mem(8'(n), 32'h0);
         for (int d = 200; d < 216; d++)
            load_mem(8'(d), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
         case ($urandom_range(0, 2))
            0:       ak0 = 32'h0;
            1:       ak0 = 32'h8000_0000 | $urandom;
            default: ak0 = $urandom_range(1, 1000);
         endcase
         set_regs(ak0, 8'h0);
         isa(ak0, mak, ml, mcyc, mcnt);
         mode = ($urandom_range(0, 3) == 3) ? 2'd3 : 2'd0;
         cnt0 = instr_count;
         pulse_start();
         cyc = 0;
         for (int k = 0; k < 3000 && running; k++) begin
            override_busy = ($urandom_range(0, 7) == 0);
            #1;
            if (!override_busy) cyc++;
            tick();
         end
         override_busy = 1'b0;
         check($sformatf("rnd%0d bound", p), {31'b0, running}, 32'd0);
         check($sformatf("rnd%0d cycles", p), cyc, mcyc);
         check($sformatf("rnd%0d ak", p), reg_ak, mak);
         check($sformatf("rnd%0d L", p), {24'b0, reg_l}, {24'b0, ml});
         check($sformatf("rnd%0d count", p), {16'b0, instr_count}, {16'b0, cnt0 + 16'(mcnt)});
         check($sformatf("rnd%0d halted", p), {31'b0, halted}, 32'd1);
         mism = 0;
         for (int d = 200; d < 216; d++) if (mem[d] !== model_mem[d]) mism++;
         check($sformatf("rnd%0d data mem", p), mism, 32'd0);
      end

      // Reset dropped mid-X2
      load_mem(0, 32'h06000001); load_mem(1, 32'h0); load_mem(6, 32'd4);
      set_regs(32'd1, 8'h0);
      mode = 2'd0;
      pulse_start();
      wait_tact(3'd4, 20);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid rst running", {31'b0, running}, 32'd0);
      check("mid rst signals", signals, 32'h0);
      check("mid rst tact", {29'b0, tact}, 32'd0);
      check("mid rst count", {16'b0, instr_count}, 32'd0);
      check("mid rst halted", {31'b0, halted}, 32'd0);
      check("mid rst fault", {31'b0, fault}, 32'd0);
      check("mid rst done", {31'b0, instr_done}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("post rst idle", {31'b0, running}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
